regfile_sb: RTL

Parametrised multi-read-port integer register file with a per-register busy scoreboard, for the NPC core datapath. It provides NREAD combinational read ports and one write port. Register 0 can optionally be hardwired to zero, and same-cycle write-to-read bypass is selectable. A busy bit per register is set when an instruction issues to it and cleared when that register is written back, so decode can stall on RAW hazards. A side debug read port serves DPI/difftest register dumps without disturbing the datapath.

---
 rtl/regfile_sb.sv | 129 ++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port integer register file with a per-register busy scoreboard.
//
// NREAD combinational read ports, one write port, an optional hardwired-zero x0 and
// optional same-cycle write-to-read forwarding. Each register has a busy bit. The bit is
// set when an instruction issues to that register and cleared when the register is
// written back. Decode uses it to stall on RAW hazards. A side debug port reads stored
// contents without forwarding, for register dumps.
//
// Ports:
//   i_clk        clock; all state updates on the rising edge
//   i_rst        asynchronous active-high reset; clears registers and busy bits
//   i_wen        write enable
//   i_waddr      write index
//   i_wdata      write data
//   i_raddr      packed read indices, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   o_rdata      packed read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   o_rbusy      per-port busy flag (register awaiting writeback)
//   i_set_en     mark i_set_addr busy (instruction issued)
//   i_set_addr   destination index being issued
//   o_busy_vec   raw stored busy bits, no forwarding
//   i_dbg_addr   debug read index
//   o_dbg_data   debug read data, stored contents only
module regfile_sb #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NREAD      = 2,
  parameter bit          BYPASS     = 1'b1,
  parameter bit          ZERO_REG   = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_wen,
  input  logic [ADDR_WIDTH-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0]         i_wdata,
  input  logic [NREAD*ADDR_WIDTH-1:0]   i_raddr,
  output logic [NREAD*DATA_WIDTH-1:0]   o_rdata,
  output logic [NREAD-1:0]              o_rbusy,
  input  logic                          i_set_en,
  input  logic [ADDR_WIDTH-1:0]         i_set_addr,
  output logic [(2**ADDR_WIDTH)-1:0]    o_busy_vec,
  input  logic [ADDR_WIDTH-1:0]         i_dbg_addr,
  output logic [DATA_WIDTH-1:0]         o_dbg_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_busy;
  logic [DEPTH-1:0]      w_busy_d;

  logic                  w_wr_eff;
  logic                  w_set_eff;
  logic [ADDR_WIDTH-1:0] w_raddr [NREAD];

  // With a hardwired x0, writes and issues targeting index 0 are dropped entirely.
  assign w_wr_eff  = i_wen    & ~(ZERO_REG & (i_waddr == '0));
  assign w_set_eff = i_set_en & ~(ZERO_REG & (i_set_addr == '0));

  for (genvar gi = 0; gi < NREAD; gi++) begin : g_raddr
    assign w_raddr[gi] = i_raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
  end

  // Register storage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_eff) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Busy next state. Clear is applied first so a same-index set wins: the newly
  // issued producer has not written back yet.
  always_comb begin
    w_busy_d = r_busy;
    if (w_wr_eff) begin
      w_busy_d[i_waddr] = 1'b0;
    end
    if (w_set_eff) begin
      w_busy_d[i_set_addr] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_d;
    end
  end

  // Read ports resolve independently; several may name the same index.
  always_comb begin
    o_rdata = '0;
    o_rbusy = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      if (ZERO_REG && (w_raddr[p] == '0)) begin
        o_rdata[p*DATA_WIDTH +: DATA_WIDTH] = '0;
        o_rbusy[p]                          = 1'b0;
      end else if (BYPASS && w_wr_eff && (i_waddr == w_raddr[p])) begin
        // The in-flight writeback satisfies the reader, so it is no longer busy.
        o_rdata[p*DATA_WIDTH +: DATA_WIDTH] = i_wdata;
        o_rbusy[p]                          = 1'b0;
      end else begin
        o_rdata[p*DATA_WIDTH +: DATA_WIDTH] = r_mem[w_raddr[p]];
        o_rbusy[p]                          = r_busy[w_raddr[p]];
      end
    end
  end

  // Debug and raw busy views never forward, so dumps reflect committed state only.
  always_comb begin
    o_busy_vec = r_busy;
    if (ZERO_REG) begin
      o_busy_vec[0] = 1'b0;
    end
  end

  always_comb begin
    if (ZERO_REG && (i_dbg_addr == '0)) begin
      o_dbg_data = '0;
    end else begin
      o_dbg_data = r_mem[i_dbg_addr];
    end
  end

endmodule
